// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
//   Two-requester round-robin scheduler in front of one shared combinational
//   8-bit ALU. One operation is in flight at a time:
//     IDLE -> (accept) -> EXEC -> (capture ALU result) -> RESP -> (handshake)
//   Operands/opcode to the ALU are registered at accept. The ALU result is
//   captured at the end of EXEC and returned to the requester that issued it.
//   Per-requester completion counters wrap modulo 2^CNT_W.
//
// Ports
//   clk, rst                      : clock (rising edge), async active-high reset
//   reqN_valid/ready/a/b/op       : request channel of requester N (N = 0, 1)
//   rspN_valid/ready              : response handshake of requester N
//   rsp_data, rsp_cout            : captured ALU result/carry (shared bus)
//   alu_a, alu_b, alu_opcode      : registered ALU inputs
//   alu_out, alu_cout             : ALU result/carry
//   busy                          : state is not IDLE
//   grant_id                      : requester owning the current operation
//   cnt0, cnt1                    : completed operations per requester
// -----------------------------------------------------------------------------
module alu_rr_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic [2:0]       req0_op,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   input  logic [2:0]       req1_op,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [15:0]      rsp_data,
   output logic             rsp_cout,

   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [2:0]       alu_opcode,
   input  logic [15:0]      alu_out,
   input  logic             alu_cout,

   output logic             busy,
   output logic             grant_id,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               grant_q, grant_d;
   logic [7:0]         alu_a_q, alu_a_d;
   logic [7:0]         alu_b_q, alu_b_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic [15:0]        rsp_data_q, rsp_data_d;
   logic               rsp_cout_q, rsp_cout_d;
   logic [CNT_W-1:0]   cnt0_q, cnt0_d;
   logic [CNT_W-1:0]   cnt1_q, cnt1_d;

   logic               rdy0_c, rdy1_c;
   logic               rsp0_vld_c, rsp1_vld_c;
   logic               rsp_take_c;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;   // requester 0 wins the first contention
         grant_q      <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_data_q   <= '0;
         rsp_cout_q   <= 1'b0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_data_q   <= rsp_data_d;
         rsp_cout_q   <= rsp_cout_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next state / outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_data_d   = rsp_data_q;
      rsp_cout_d   = rsp_cout_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      rdy0_c       = 1'b0;
      rdy1_c       = 1'b0;
      rsp0_vld_c   = 1'b0;
      rsp1_vld_c   = 1'b0;
      rsp_take_c   = 1'b0;

      case (state_q)
         IDLE: begin
            // Round robin: under contention the requester that did not win
            // last time goes next; an uncontested requester always wins.
            rdy0_c = req0_valid & (~req1_valid | last_grant_q);
            rdy1_c = req1_valid & (~req0_valid | ~last_grant_q);
            if (rdy0_c) begin
               alu_a_d      = req0_a;
               alu_b_d      = req0_b;
               alu_op_d     = req0_op;
               grant_d      = 1'b0;
               last_grant_d = 1'b0;
               state_d      = EXEC;
            end else if (rdy1_c) begin
               alu_a_d      = req1_a;
               alu_b_d      = req1_b;
               alu_op_d     = req1_op;
               grant_d      = 1'b1;
               last_grant_d = 1'b1;
               state_d      = EXEC;
            end
         end

         EXEC: begin
            // ALU inputs have been stable for a full cycle; sample its result.
            rsp_data_d = alu_out;
            rsp_cout_d = alu_cout;
            state_d    = RESP;
         end

         RESP: begin
            rsp0_vld_c = ~grant_q;
            rsp1_vld_c = grant_q;
            // Only the owner's ready completes the response.
            rsp_take_c = grant_q ? rsp1_ready : rsp0_ready;
            if (rsp_take_c) begin
               if (grant_q) cnt1_d = cnt1_q + CNT_W'(1);
               else         cnt0_d = cnt0_q + CNT_W'(1);
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Readies are combinational from the valids; force them low while reset
   // is asserted so every output reads zero during reset.
   assign req0_ready = rdy0_c & ~rst;
   assign req1_ready = rdy1_c & ~rst;
   assign rsp0_valid = rsp0_vld_c;
   assign rsp1_valid = rsp1_vld_c;
   assign rsp_data   = rsp_data_q;
   assign rsp_cout   = rsp_cout_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
module tb_alu_rr_sched;
   localparam int CW = 4;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_SHL = 3'd3,
                          OP_SHR = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_XOR = 3'd7;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]    req0_a, req0_b, req1_a, req1_b;
   logic [2:0]    req0_op, req1_op;
   logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [15:0]   rsp_data;
   logic          rsp_cout;
   logic [7:0]    alu_a, alu_b;
   logic [2:0]    alu_opcode;
   logic [15:0]   alu_out;
   logic          alu_cout;
   logic          busy, grant_id;
   logic [CW-1:0] cnt0, cnt1;

   always #5 clk = ~clk;

   alu_rr_sched #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_cout(rsp_cout),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_cout(alu_cout),
      .busy(busy), .grant_id(grant_id), .cnt0(cnt0), .cnt1(cnt1)
   );

   // Combinational ALU attached to the scheduler
   always_comb begin
      alu_out  = 16'h0000;
      alu_cout = 1'b0;
      case (alu_opcode)
         OP_ADD: begin alu_out = {8'h00, alu_a} + {8'h00, alu_b}; alu_cout = alu_out[8]; end
         OP_SUB: begin alu_out = {8'h00, alu_a} - {8'h00, alu_b}; alu_cout = (alu_a < alu_b); end
         OP_MUL: alu_out = {8'h00, alu_a} * {8'h00, alu_b};
         OP_SHL: alu_out = {8'h00, alu_a} << alu_b[3:0];
         OP_SHR: alu_out = {8'h00, alu_a} >> alu_b[3:0];
         OP_AND: alu_out = {8'h00, alu_a & alu_b};
         OP_OR:  alu_out = {8'h00, alu_a | alu_b};
         default: alu_out = {8'h00, alu_a ^ alu_b};
      endcase
   end

   typedef struct packed {
      logic        id;
      logic [15:0] data;
      logic        cout;
   } exp_t;

   exp_t          sb[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic          exp_lg;
   logic [CW-1:0] exp_cnt0, exp_cnt1;

   // Reference result computed with integer arithmetic
   function automatic exp_t ref_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] op);
      exp_t e;
      int ia, ib, r;
      ia = int'(a); ib = int'(b); r = 0;
      e.id = id; e.cout = 1'b0;
      case (op)
         OP_ADD: begin r = ia + ib; e.cout = (r > 255); end
         OP_SUB: begin r = ia - ib; e.cout = (ia < ib); end
         OP_MUL: r = ia * ib;
         OP_SHL: r = ia * (1 << (ib % 16));
         OP_SHR: r = ia / (1 << (ib % 16));
         OP_AND: r = ia & ib;
         OP_OR:  r = ia | ib;
         default: r = ia ^ ib;
      endcase
      e.data = r[15:0];
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      rsp0_ready = 0; rsp1_ready = 0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;
      exp_lg = 1'b1; exp_cnt0 = '0; exp_cnt1 = '0;
      sb.delete();
   endtask

   task automatic test_reset();
      logic [46:0] outs;
      clear_inputs();
      rst = 1'b1;
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      #1;
      outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout, alu_a, alu_b,
              alu_opcode, busy, grant_id, cnt0, cnt1};
      n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      step();
      clear_inputs();
      rst = 1'b0;
      #1;
      exp_lg = 1'b1; exp_cnt0 = '0; exp_cnt1 = '0; sb.delete();
      n_tests++; if ({busy, req0_ready, req1_ready, cnt0, cnt1} !== '0) begin
         n_fail++; $display("FAIL reset_release busy=%b r0=%b r1=%b c0=%0d c1=%0d exp all 0",
                            busy, req0_ready, req1_ready, cnt0, cnt1); end
   endtask

   task automatic test_basic();
      exp_t e;
      apply_reset();
      req0_valid = 1; req0_a = 8'd200; req0_b = 8'd100; req0_op = OP_ADD;
      #1;
      n_tests++; if ({req1_ready, req0_ready} !== 2'b01) begin
         n_fail++; $display("FAIL basic_ready_c0 got=%b exp=01", {req1_ready, req0_ready}); end
      sb.push_back(ref_op(0, req0_a, req0_b, req0_op));
      step();
      req0_valid = 0; req0_a = 8'h11;
      n_tests++; if ({busy, grant_id, rsp0_valid, alu_a, alu_b, alu_opcode} !== {1'b1, 1'b0, 1'b0, 8'd200, 8'd100, OP_ADD}) begin
         n_fail++; $display("FAIL basic_exec busy=%b gid=%b v=%b a=%0d b=%0d op=%0d exp 1 0 0 200 100 0",
                            busy, grant_id, rsp0_valid, alu_a, alu_b, alu_opcode); end
      step();
      n_tests++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin
         n_fail++; $display("FAIL basic_rsp_c2 got=%b exp=01", {rsp1_valid, rsp0_valid}); end
      n_tests++; if ({rsp_data, rsp_cout} !== {16'h012C, 1'b1}) begin
         n_fail++; $display("FAIL basic_result got=%h/%b exp=012c/1", rsp_data, rsp_cout); end
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_tests++; if ({rsp_data, rsp_cout} !== {e.data, e.cout}) begin
         n_fail++; $display("FAIL basic_sb got=%h/%b exp=%h/%b", rsp_data, rsp_cout, e.data, e.cout); end
      rsp0_ready = 1;
      step();
      rsp0_ready = 0;
      exp_cnt0++;
      n_tests++; if ({cnt0, busy, rsp0_valid} !== {exp_cnt0, 2'b00}) begin
         n_fail++; $display("FAIL basic_cnt cnt0=%0d busy=%b v=%b exp %0d 0 0", cnt0, busy, rsp0_valid, exp_cnt0); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      req1_valid = 1; req1_a = 8'd5; req1_b = 8'd10; req1_op = OP_SUB;
      #1;
      n_tests++; if ({req1_ready, req0_ready} !== 2'b10) begin
         n_fail++; $display("FAIL bp_ready got=%b exp=10", {req1_ready, req0_ready}); end
      sb.push_back(ref_op(1, req1_a, req1_b, req1_op));
      exp_lg = 1;
      step();
      req1_valid = 0;
      step();
      for (int i = 0; i < 4; i++) begin
         n_tests++; if ({rsp1_valid, rsp0_valid, rsp_data, cnt1} !== {2'b10, 16'hFFFB, exp_cnt1}) begin
            n_fail++; $display("FAIL bp_hold[%0d] v=%b%b data=%h cnt1=%0d exp 10 fffb %0d",
                               i, rsp1_valid, rsp0_valid, rsp_data, cnt1, exp_cnt1); end
         step();
      end
      rsp1_ready = 1;
      #1;
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_tests++; if ({rsp1_valid, rsp_data, rsp_cout} !== {1'b1, e.data, e.cout}) begin
         n_fail++; $display("FAIL bp_result v=%b got=%h/%b exp=%h/%b", rsp1_valid, rsp_data, rsp_cout, e.data, e.cout); end
      step();
      rsp1_ready = 0;
      exp_cnt1++;
      n_tests++; if ({cnt1, rsp1_valid, busy} !== {exp_cnt1, 2'b00}) begin
         n_fail++; $display("FAIL bp_cnt cnt1=%0d v=%b busy=%b exp %0d 0 0", cnt1, rsp1_valid, busy, exp_cnt1); end
   endtask

   task automatic test_alternate();
      exp_t e;
      logic exp_g;
      int   grants;
      apply_reset();
      req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255; req0_op = OP_MUL;
      req1_valid = 1; req1_a = 8'h81;  req1_b = 8'd4;   req1_op = OP_SHL;
      rsp0_ready = 1; rsp1_ready = 1;
      exp_g = 1'b0; grants = 0;
      #1;
      for (int c = 0; c < 30; c++) begin
         if (req0_ready | req1_ready) begin
            n_tests++; if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL alt_grant[%0d] got=%b exp_id=%b", grants, {req1_ready, req0_ready}, exp_g); end
            sb.push_back(exp_g ? ref_op(1, req1_a, req1_b, req1_op) : ref_op(0, req0_a, req0_b, req0_op));
            exp_g = ~exp_g;
            grants++;
         end
         if (rsp0_valid | rsp1_valid) begin
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            n_tests++; if ({rsp1_valid, rsp0_valid, grant_id, rsp_data, rsp_cout} !== {e.id, ~e.id, e.id, e.data, e.cout}) begin
               n_fail++; $display("FAIL alt_rsp v=%b%b gid=%b data=%h/%b exp id=%b data=%h/%b",
                                  rsp1_valid, rsp0_valid, grant_id, rsp_data, rsp_cout, e.id, e.data, e.cout); end
            n_tests++; if (rsp_data !== (e.id ? 16'h0810 : 16'hFE01)) begin
               n_fail++; $display("FAIL alt_const data=%h exp=%h", rsp_data, e.id ? 16'h0810 : 16'hFE01); end
            if (e.id) exp_cnt1++; else exp_cnt0++;
         end
         step();
      end
      clear_inputs();
      n_tests++; if (grants !== 10) begin n_fail++; $display("FAIL alt_count grants=%0d exp=10", grants); end
      n_tests++; if ({cnt0, cnt1} !== {exp_cnt0, exp_cnt1}) begin
         n_fail++; $display("FAIL alt_cnts got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, exp_cnt0, exp_cnt1); end
   endtask

   task automatic test_reset_mid();
      logic [46:0] outs;
      apply_reset();
      req0_valid = 1; req0_a = 8'h5A; req0_b = 8'h3C; req0_op = OP_XOR;
      #1;
      n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got=%b exp=1", req0_ready); end
      step();
      req0_valid = 0;
      n_tests++; if ({busy, alu_opcode} !== {1'b1, OP_XOR}) begin
         n_fail++; $display("FAIL rmid_exec busy=%b op=%0d exp 1 7", busy, alu_opcode); end
      rst = 1'b1; req1_valid = 1; rsp0_ready = 1;
      #1;
      outs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_cout, alu_a, alu_b,
              alu_opcode, busy, grant_id, cnt0, cnt1};
      n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rmid_outputs got=%h exp=0", outs); end
      step();
      rst = 1'b0; req1_valid = 0;
      exp_lg = 1'b1; exp_cnt0 = '0; exp_cnt1 = '0; sb.delete();
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++; if ({rsp0_valid, busy, cnt0} !== '0) begin
            n_fail++; $display("FAIL rmid_drop[%0d] v=%b busy=%b cnt0=%0d exp 0 0 0", i, rsp0_valid, busy, cnt0); end
      end
      rsp0_ready = 0;
      req0_valid = 1; req1_valid = 1;
      #1;
      n_tests++; if ({req1_ready, req0_ready} !== 2'b01) begin
         n_fail++; $display("FAIL rmid_first_grant got=%b exp=01", {req1_ready, req0_ready}); end
      clear_inputs();
   endtask

   task automatic test_wrap();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         req0_valid = 1; req0_a = 8'(i * 13); req0_b = 8'(i * 7 + 3); req0_op = 3'(i % 8);
         #1;
         n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d] got=%b exp=1", i, req0_ready); end
         sb.push_back(ref_op(0, req0_a, req0_b, req0_op));
         step();
         req0_valid = 0;
         step();
         e = (sb.size() != 0) ? sb.pop_front() : '0;
         n_tests++; if ({rsp0_valid, rsp_data, rsp_cout} !== {1'b1, e.data, e.cout}) begin
            n_fail++; $display("FAIL wrap_rsp[%0d] v=%b got=%h/%b exp=%h/%b", i, rsp0_valid, rsp_data, rsp_cout, e.data, e.cout); end
         rsp0_ready = 1;
         step();
         rsp0_ready = 0;
         exp_cnt0++;
         n_tests++; if (cnt0 !== exp_cnt0) begin n_fail++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, cnt0, exp_cnt0); end
      end
      exp_lg = 1'b0;
      n_tests++; if (cnt0 !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", cnt0); end
   endtask

   task automatic test_ignore_ready();
      exp_t e;
      req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = OP_AND;
      #1;
      n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL ign_accept got=%b exp=1", req1_ready); end
      sb.push_back(ref_op(1, req1_a, req1_b, req1_op));
      step();
      req1_valid = 0;
      req0_valid = 1; req0_op = OP_OR;
      step();
      rsp0_ready = 1;
      for (int i = 0; i < 3; i++) begin
         req0_a = 8'($urandom); req0_b = 8'($urandom);
         #1;
         n_tests++; if ({busy, rsp1_valid, rsp0_valid, req0_ready, cnt0} !== {4'b1100, exp_cnt0}) begin
            n_fail++; $display("FAIL ign_hold[%0d] busy=%b v=%b%b r0=%b cnt0=%0d exp 1 10 0 %0d",
                               i, busy, rsp1_valid, rsp0_valid, req0_ready, cnt0, exp_cnt0); end
         step();
      end
      rsp1_ready = 1;
      req0_a = 8'hA5; req0_b = 8'h0F;
      #1;
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_tests++; if ({rsp_data, rsp_cout} !== {e.data, e.cout}) begin
         n_fail++; $display("FAIL ign_result got=%h/%b exp=%h/%b", rsp_data, rsp_cout, e.data, e.cout); end
      step();
      rsp1_ready = 0;
      exp_cnt1++;
      n_tests++; if ({cnt1, cnt0, req0_ready} !== {exp_cnt1, exp_cnt0, 1'b1}) begin
         n_fail++; $display("FAIL ign_after c1=%0d c0=%0d r0=%b exp %0d %0d 1", cnt1, cnt0, req0_ready, exp_cnt1, exp_cnt0); end
      sb.push_back(ref_op(0, 8'hA5, 8'h0F, OP_OR));
      step();
      req0_valid = 0; req0_a = 8'h00; req0_b = 8'hFF;
      step();
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      n_tests++; if ({rsp0_valid, rsp_data} !== {1'b1, e.data}) begin
         n_fail++; $display("FAIL ign_req0 v=%b got=%h exp=%h", rsp0_valid, rsp_data, e.data); end
      step();
      rsp0_ready = 0;
      exp_cnt0++;
      exp_lg = 1'b0;
      n_tests++; if (cnt0 !== exp_cnt0) begin n_fail++; $display("FAIL ign_cnt0 got=%0d exp=%0d", cnt0, exp_cnt0); end
   endtask

   task automatic test_random();
      exp_t e;
      int   ms;
      logic mg;
      logic [1:0] er;
      apply_reset();
      ms = 0; mg = 0;
      for (int c = 0; c < 400; c++) begin
         req0_valid = ($urandom_range(0, 3) != 0); req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
         req1_valid = ($urandom_range(0, 3) != 0); req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
         rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
         #1;
         er = 2'b00;
         if (ms == 0) begin
            er[0] = req0_valid & (~req1_valid | exp_lg);
            er[1] = req1_valid & (~req0_valid | ~exp_lg);
         end
         n_tests++; if ({req1_ready, req0_ready, busy, rsp1_valid, rsp0_valid} !==
                        {er, (ms != 0), (ms == 2) & mg, (ms == 2) & ~mg}) begin
            n_fail++; $display("FAIL rnd_ctrl[%0d] rdy=%b%b busy=%b v=%b%b exp rdy=%b ms=%0d id=%b",
                               c, req1_ready, req0_ready, busy, rsp1_valid, rsp0_valid, er, ms, mg); end
         if (ms == 2) begin
            e = (sb.size() != 0) ? sb[0] : '0;
            n_tests++; if ({rsp_data, rsp_cout} !== {e.data, e.cout}) begin
               n_fail++; $display("FAIL rnd_data[%0d] got=%h/%b exp=%h/%b", c, rsp_data, rsp_cout, e.data, e.cout); end
            if (mg ? rsp1_ready : rsp0_ready) begin
               if (sb.size() != 0) void'(sb.pop_front());
               if (mg) exp_cnt1++; else exp_cnt0++;
               ms = 0;
            end
         end else if (ms == 1) begin
            ms = 2;
         end else if (er != 2'b00) begin
            mg = er[1];
            exp_lg = er[1];
            sb.push_back(er[1] ? ref_op(1, req1_a, req1_b, req1_op) : ref_op(0, req0_a, req0_b, req0_op));
            ms = 1;
         end
         step();
      end
      clear_inputs();
      n_tests++; if ({cnt0, cnt1} !== {exp_cnt0, exp_cnt1}) begin
         n_fail++; $display("FAIL rnd_cnts got=%0d/%0d exp=%0d/%0d", cnt0, cnt1, exp_cnt0, exp_cnt1); end
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      exp_lg = 1'b1; exp_cnt0 = '0; exp_cnt1 = '0;
      #3;
      test_reset();
      test_basic();
      test_backpressure();
      test_alternate();
      test_reset_mid();
      test_wrap();
      test_ignore_ready();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Two-requester round-robin scheduler sharing one combinational 8-bit ALU (ops: add/sub/mul/shl/shr/and/or/xor, 3-bit opcode, 16-bit result, carry flag).
- Accepts one operation at a time via valid/ready, drives registered operands and opcode to the ALU, and captures its result.
- Returns the result to the originating requester via a response handshake.
- Keeps per-requester completion counters for debug and perf visibility.

Parameters:
- CNT_W, 16, width of per-requester completed-operation counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req0_a  in  8  requester 0 operand a.
- req0_b  in  8  requester 0 operand b.
- req0_op  in  3  requester 0 ALU opcode.
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 takes result.
- rsp_data  out  16  captured ALU result; shared, meaningful only while a rspN_valid is high.
- rsp_cout  out  1  captured ALU carry.
- alu_a  out  8  registered operand to ALU.
- alu_b  out  8  registered operand to ALU.
- alu_opcode  out  3  registered opcode to ALU.
- alu_out  in  16  ALU result.
- alu_cout  in  1  ALU carry.
- busy  out  1  high when state is not IDLE.
- grant_id  out  1  requester owning the current operation.
- cnt0  out  CNT_W  completed ops for requester 0.
- cnt1  out  CNT_W  completed ops for requester 1.

Behaviour:
- **Reset:** rst high forces immediately: state=IDLE, all outputs 0, last_grant=1 (so requester 0 wins first contention), cnt0=cnt1=0.
- **Reset mid-operation:** the in-flight op is dropped with no response and no counter increment.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE, arbitration:**
  - req0_ready = valid0 & (!valid1 | last_grant==1).
  - req1_ready = valid1 & (!valid0 | last_grant==0).
  - At most one ready is high; readies are 0 in every other state.
- **IDLE, handshake** (valid & ready): latch a/b/op into alu_a/alu_b/alu_opcode; set grant_id and last_grant to the winner; go to EXEC.
- **IDLE, no valid:** remain in IDLE; ALU outputs hold their previous values.
- **EXEC:** one cycle with ALU inputs stable. At its closing edge, capture rsp_data<=alu_out and rsp_cout<=alu_cout; go to RESP.
- **RESP:**
  - rsp[grant_id]_valid=1; the other rsp_valid stays 0.
  - rsp_data/rsp_cout are held stable until the handshake.
  - On rsp[grant_id]_ready: increment cnt[grant_id] (wraps modulo 2^CNT_W, no saturation), clear rsp_valid, go to IDLE.
  - rsp_ready from the non-granted requester is ignored.
- **Latency and throughput:** accept at cycle N; rsp_valid high from cycle N+2. A new request is accepted no earlier than the cycle after the response handshake, giving a minimum of 3 cycles per operation.
- **Back-pressure:** a requester holding valid with changing operands before ready is legal; only values at the handshake edge are used.
- **Starvation:** with both requesters continuously valid, grants alternate strictly 0,1,0,1,...
- **Width:** the scheduler does not modify data; result width and carry semantics are the ALU's (8-bit operands, 16-bit result).

Test Plan:
- Reset then req0 add a=200 b=100 -> req0_ready at cycle 0; rsp0_valid at cycle 2; rsp_data=0x012C, rsp_cout=1; cnt0=1 after the rsp handshake.
- req1 sub a=5 b=10 with rsp1_ready held low for 4 cycles -> rsp1_valid stays high; rsp_data=0xFFFB held stable; cnt1 increments only on the ready cycle.
- Both valid continuously from reset with mul 255*255 (req0) and shl 0x81<<4 (req1) -> grants alternate 0,1,0,1; rsp_data=0xFE01 for req0 and 0x0810 for req1; rsp1_valid never asserts on a req0 op.
- Assert rst during EXEC of a req0 xor -> all outputs 0 immediately; no rsp0_valid after release; cnt0 unchanged (0); next contention grants req0.
- Preload cnt0 near wrap (CNT_W=4, 16 completed ops) -> cnt0 returns to 0 after the 16th completion.
- rsp0_ready asserted while requester 1 owns RESP -> ignored; state stays RESP until rsp1_ready.
